// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout,sum} = a + b + cin, built from BLOCK-bit ripple sections.
// Latency 1 cycle, one operation accepted per cycle; sum/cout hold when in_valid is low.
// No backpressure: the block is always ready, out_valid pulses one cycle after each in_valid.
module carry_select_adder #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int NSEC = (BLOCK > 0) ? (WIDTH / BLOCK) : 1;

  // Reject illegal geometries at elaboration rather than building a truncated adder.
  if (WIDTH < 1 || BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("carry_select_adder: WIDTH must be >= 1 and a multiple of BLOCK, with 1 <= BLOCK <= WIDTH");
  end

  // One BLOCK-bit ripple chain of full-adder cells; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             c);
    logic [BLOCK-1:0] s;
    logic             cc;
    s  = '0;
    cc = c;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    return {cc, s};
  endfunction

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  // Each section keeps its own carry-out so the chain is a set of distinct nets,
  // not feedback through one shared vector.
  for (genvar k = 0; k < NSEC; k++) begin : g_sec
    logic [BLOCK-1:0] xa;
    logic [BLOCK-1:0] xb;
    logic             co;

    assign xa = a[k*BLOCK +: BLOCK];
    assign xb = b[k*BLOCK +: BLOCK];

    if (k == 0) begin : g_ripple
      // Lowest section sees cin directly, so there is nothing to select.
      logic [BLOCK:0] r;
      assign r                   = ripple(xa, xb, cin);
      assign sum_d[BLOCK-1:0]    = r[BLOCK-1:0];
      assign co                  = r[BLOCK];
    end else begin : g_select
      // Both carry-in outcomes are computed in parallel; the lower carry only drives the mux.
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      logic [BLOCK:0] rs;
      assign r0                        = ripple(xa, xb, 1'b0);
      assign r1                        = ripple(xa, xb, 1'b1);
      assign rs                        = g_sec[k-1].co ? r1 : r0;
      assign sum_d[k*BLOCK +: BLOCK]   = rs[BLOCK-1:0];
      assign co                        = rs[BLOCK];
    end
  end

  assign cout_d = g_sec[NSEC-1].co;

  // Result register: clear on reset, load on valid, otherwise hold with out_valid low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Bench for carry_select_adder: W4 with BLOCK 1/2/4 and W16 with BLOCK 4 side by side.
// Each result is expected one cycle after its input, against a plain-arithmetic model.
// The DUT has no backpressure; in_valid is driven freely, including random gaps.
module tb_carry_select_adder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic        cin;
  logic        in_valid;

  logic [3:0]  s1, s2, s4;
  logic        c1, c2, c4, v1, v2, v4;
  logic [15:0] s16;
  logic        c16, v16;

  int pass_cnt  = 0;
  int total_cnt = 0;

  carry_select_adder #(.WIDTH(4), .BLOCK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .in_valid(in_valid),
    .sum(s2), .cout(c2), .out_valid(v2));

  carry_select_adder #(.WIDTH(4), .BLOCK(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .in_valid(in_valid),
    .sum(s1), .cout(c1), .out_valid(v1));

  carry_select_adder #(.WIDTH(4), .BLOCK(4)) u_dut_b4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .in_valid(in_valid),
    .sum(s4), .cout(c4), .out_valid(v4));

  carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_dut_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin), .in_valid(in_valid),
    .sum(s16), .cout(c16), .out_valid(v16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the WIDTH+1-bit arithmetic sum.
  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return 5'(x) + 5'(y) + 5'(c);
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  // Advance past the next rising edge and settle before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if ({c2, s2, v2} !== 6'b0) $display("FAIL reset_outputs cyc=%0d got cout=%b sum=%b vld=%b want 0/0000/0", i, c2, s2, v2);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({c2, s2} !== ref4(4'hF, 4'hF, 1'b0)) $display("FAIL reset_first_result got %b want %b", {c2, s2}, ref4(4'hF, 4'hF, 1'b0));
    else pass_cnt++;
    total_cnt++;
    if (v2 !== 1'b1) $display("FAIL reset_first_valid got %b want 1", v2);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [3:0] ta [8] = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hF, 4'hA, 4'h3, 4'hF};
    logic [3:0] tb [8] = '{4'h0, 4'h1, 4'h5, 4'h3, 4'hF, 4'h5, 4'h1, 4'h0};
    logic       tc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] exp;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a4 = ta[i]; b4 = tb[i]; cin = tc[i];
      exp = ref4(ta[i], tb[i], tc[i]);
      tick();
      total_cnt++;
      if ({c2, s2} !== exp || v2 !== 1'b1)
        $display("FAIL directed[%0d] %h+%h+%b got cout/sum=%b vld=%b want %b vld=1", i, ta[i], tb[i], tc[i], {c2, s2}, v2, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    in_valid = 1'b1; a4 = 4'h6; b4 = 4'h3; cin = 1'b1;
    tick();
    total_cnt++;
    if (s2 !== 4'b1010 || c2 !== 1'b0 || v2 !== 1'b1) $display("FAIL hold_load got %b/%b vld=%b want 0/1010 vld=1", c2, s2, v2);
    else pass_cnt++;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin = 1'($urandom);
      tick();
      total_cnt++;
      if (s2 !== 4'b1010 || c2 !== 1'b0 || v2 !== 1'b0) $display("FAIL hold_cycle[%0d] got %b/%b vld=%b want 0/1010 vld=0", i, c2, s2, v2);
      else pass_cnt++;
    end
  endtask

  task automatic test_midreset;
    in_valid = 1'b1; a4 = 4'h1; b4 = 4'h1; cin = 1'b0;
    tick();
    a4 = 4'h7; b4 = 4'h7; cin = 1'b0; rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({c2, s2, v2} !== 6'b0) $display("FAIL midreset_clear got %b/%b vld=%b want 0/0000/0", c2, s2, v2);
    else pass_cnt++;
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    total_cnt++;
    if ({c2, s2, v2} !== 6'b0) $display("FAIL midreset_discard got %b/%b vld=%b want 0/0000/0", c2, s2, v2);
    else pass_cnt++;
  endtask

  // Random valid gaps: the model holds the last accepted sum between valid cycles.
  task automatic test_back_to_back;
    logic [4:0] held;
    logic       vld;
    held = 5'b0;
    for (int i = 0; i < 120; i++) begin
      vld = 1'($urandom);
      in_valid = vld; a4 = 4'($urandom); b4 = 4'($urandom); cin = 1'($urandom);
      if (vld) held = ref4(a4, b4, cin);
      tick();
      total_cnt++;
      if ({c2, s2} !== held || v2 !== vld)
        $display("FAIL back_to_back[%0d] got %b vld=%b want %b vld=%b", i, {c2, s2}, v2, held, vld);
      else pass_cnt++;
    end
  endtask

  task automatic test_exhaustive;
    logic [4:0] exp;
    in_valid = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(x); b4 = 4'(y); cin = 1'(c);
          exp = ref4(4'(x), 4'(y), 1'(c));
          tick();
          total_cnt++;
          if ({c1, s1} !== exp || v1 !== 1'b1) $display("FAIL exh_b1 %0d+%0d+%0d got %b want %b", x, y, c, {c1, s1}, exp);
          else pass_cnt++;
          total_cnt++;
          if ({c2, s2} !== exp || v2 !== 1'b1) $display("FAIL exh_b2 %0d+%0d+%0d got %b want %b", x, y, c, {c2, s2}, exp);
          else pass_cnt++;
          total_cnt++;
          if ({c4, s4} !== exp || v4 !== 1'b1) $display("FAIL exh_b4 %0d+%0d+%0d got %b want %b", x, y, c, {c4, s4}, exp);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_random16;
    logic [16:0] exp;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 0)      begin a16 = 16'hFFFF; b16 = 16'h0000; cin = 1'b1; end
      else if (i == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; cin = 1'b1; end
      else if (i == 2) begin a16 = 16'h0FFF; b16 = 16'h0001; cin = 1'b0; end
      else begin a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'($urandom); end
      exp = ref16(a16, b16, cin);
      tick();
      total_cnt++;
      if ({c16, s16} !== exp || v16 !== 1'b1)
        $display("FAIL rand16[%0d] got %h vld=%b want %h", i, {c16, s16}, v16, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a4 = '0; b4 = '0; a16 = '0; b16 = '0; cin = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_midreset();
    test_back_to_back();
    test_exhaustive();
    test_random16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
